// File: rtl/axil_array_arbiter.sv
// axil_array_arbiter: round-robin sharing of one synchronous array port between
// an AXI-lite-style read channel and write channel, with read-data FIFO and write-response counter.
module axil_array_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_DEPTH = 3,
  parameter int B_MAX    = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [ADDR_W-1:0] sRA,
  input  logic              sRA_valid,
  output logic              sRA_ready,
  output logic [DATA_W-1:0] sR,
  output logic              sR_valid,
  input  logic              sR_ready,
  input  logic [ADDR_W-1:0] sWA,
  input  logic              sWA_valid,
  output logic              sWA_ready,
  input  logic [DATA_W-1:0] sW,
  input  logic              sW_valid,
  output logic              sW_ready,
  output logic              sB_valid,
  input  logic              sB_ready,
  output logic [ADDR_W-1:0] arr_addr,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_di,
  input  logic [DATA_W-1:0] arr_do
);
  localparam int CW = $clog2(RD_DEPTH + 1);
  localparam int PW = RD_DEPTH > 1 ? $clog2(RD_DEPTH) : 1;
  localparam int BW = $clog2(B_MAX + 1);
  typedef enum logic {READ, WRITE} side_t;
  side_t             last;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     wptr, rptr;
  logic [DATA_W-1:0] fifo [RD_DEPTH];
  logic              rd_pend;
  logic [BW-1:0]     bcnt;
  logic              rd_ok, wr_ok, rd_gnt, wr_gnt, push, pop, b_pop;
  // Credit counts the in-flight read so the FIFO can never overflow on push.
  always_comb begin
    rd_ok  = sRA_valid && (int'(fifo_cnt) + int'(rd_pend) < RD_DEPTH);
    wr_ok  = sWA_valid && sW_valid && (int'(bcnt) < B_MAX);
    rd_gnt = nrst && rd_ok && (!wr_ok || last == WRITE);
    wr_gnt = nrst && wr_ok && !rd_gnt;
  end
  assign sRA_ready = rd_gnt;
  assign sWA_ready = wr_gnt;
  assign sW_ready  = wr_gnt;
  assign arr_we    = wr_gnt;
  assign arr_addr  = wr_gnt ? sWA : sRA;
  assign arr_di    = sW;
  assign push      = rd_pend;
  assign sR        = fifo[rptr];
  assign sR_valid  = fifo_cnt != '0;
  assign sB_valid  = bcnt != '0;
  assign pop       = sR_valid && sR_ready;
  assign b_pop     = sB_valid && sB_ready;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fifo_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      rd_pend  <= 1'b0;
      bcnt     <= '0;
      last     <= WRITE;
    end else begin
      rd_pend  <= rd_gnt;
      if (push) wptr <= wptr == PW'(RD_DEPTH - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == PW'(RD_DEPTH - 1) ? '0 : rptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      bcnt     <= bcnt + BW'(wr_gnt) - BW'(b_pop);
      if (rd_gnt || wr_gnt) last <= wr_gnt ? WRITE : READ;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= arr_do;
  end
endmodule
